// File: rtl/router_arb_pkg.sv
// Shared types and sizing constants for the router output-port arbiters.
package router_arb_pkg;

  localparam int DEF_NUMBER_CHANNELS = 5;
  localparam int DEF_TIMEOUT_CYCLES  = 64;
  localparam int DEF_IDX_W           = $clog2(DEF_NUMBER_CHANNELS);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Width of a counter that must be able to hold the value 'cycles'.
  function automatic int tmo_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: finds the first requester after ptr, wrapping modulo N.
// The request vector is doubled so the wrap becomes a plain lowest-bit
// search over the window ptr+1 .. ptr+N.
module rr_pick
  import router_arb_pkg::*;
#(
  parameter int N = DEF_NUMBER_CHANNELS,
  parameter int W = DEF_IDX_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] sel,
  output logic [N-1:0] onehot
);

  logic [2*N-1:0] w_double;
  logic [2*N-1:0] w_mask;
  int             w_hit;
  int             w_idx;

  assign w_double = {req, req};

  // Masked priority encode over the doubled vector, folded back to a channel.
  always_comb begin
    // NOTE: every output gets a default before any conditional code, so no
    // path can leave a value unassigned and infer a latch.
    w_mask = '0;
    w_hit  = 0;
    valid  = 1'b0;
    onehot = '0;
    for (int j = 0; j < 2*N; j++) begin
      w_mask[j] = (j > int'(ptr)) && (j <= int'(ptr) + N);
    end
    // Scan downward so the lowest set bit in the window is the one kept.
    for (int j = 2*N-1; j >= 0; j--) begin
      if (w_double[j] && w_mask[j]) begin
        w_hit = j;
        valid = 1'b1;
      end
    end
    w_idx = (w_hit >= N) ? (w_hit - N) : w_hit;
    sel   = W'(w_idx);
    for (int k = 0; k < N; k++) begin
      onehot[k] = valid && (k == w_idx);
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Output-port arbiter: round-robin grant that is locked for a whole burst
// and released one cycle after the granted channel's last beat is accepted.
// Optional stall watchdog enabled by defining ARB_TIMEOUT_EN.
module output_port_arbiter
  import router_arb_pkg::*;
#(
  parameter int NUMBER_CHANNELS = DEF_NUMBER_CHANNELS,
  parameter int IDX_W           = $clog2(NUMBER_CHANNELS),
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUMBER_CHANNELS-1:0] req,
  input  logic [NUMBER_CHANNELS-1:0] last,
  input  logic                       ready,
  output logic [NUMBER_CHANNELS-1:0] gnt,
  output logic [NUMBER_CHANNELS-1:0] ack,
  output logic                       busy,
  output logic [IDX_W-1:0]           grant_idx,
  output logic                       timeout
);

  if (NUMBER_CHANNELS < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("output_port_arbiter: NUMBER_CHANNELS and TIMEOUT_CYCLES must be >= 2");
  end

  arb_state_t                 r_state, w_next_state;
  logic [NUMBER_CHANNELS-1:0] r_gnt, w_next_gnt;
  logic                       r_busy, w_next_busy;
  logic [IDX_W-1:0]           r_grant_idx, w_next_idx;
  logic [IDX_W-1:0]           r_ptr, w_next_ptr;

  logic                       w_pick_valid;
  logic [IDX_W-1:0]           w_pick_sel;
  logic [NUMBER_CHANNELS-1:0] w_pick_onehot;
  logic                       w_beat;
  logic                       w_last_beat;
  logic                       w_force_release;

  rr_pick #(
    .N (NUMBER_CHANNELS),
    .W (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .valid  (w_pick_valid),
    .sel    (w_pick_sel),
    .onehot (w_pick_onehot)
  );

  // Only the granted channel can see an accepted beat; at most one bit set.
  assign ack         = r_gnt & req & {NUMBER_CHANNELS{ready}};
  assign w_beat      = |ack;
  assign w_last_beat = |(ack & last);

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = tmo_width(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_timeout;

  assign w_force_release = (r_state == GRANT) && !w_beat &&
                           (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign timeout = r_timeout;

  // Stall counter: counts granted cycles without a beat, cleared otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_force_release;
      if (r_state != GRANT || w_beat || w_force_release) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
    end
  end
`else
  assign w_force_release = 1'b0;
  assign timeout         = 1'b0;
`endif

  // Next-state logic: grant from IDLE, release on last beat or watchdog.
  always_comb begin
    w_next_state = r_state;
    w_next_gnt   = r_gnt;
    w_next_busy  = r_busy;
    w_next_idx   = r_grant_idx;
    w_next_ptr   = r_ptr;
    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_next_state = GRANT;
          w_next_gnt   = w_pick_onehot;
          w_next_busy  = 1'b1;
          w_next_idx   = w_pick_sel;
        end
      end
      GRANT: begin
        if (w_last_beat || w_force_release) begin
          w_next_state = IDLE;
          w_next_gnt   = '0;
          w_next_busy  = 1'b0;
          w_next_ptr   = r_grant_idx;
        end
      end
    endcase
  end

  // State register; pointer starts at the top so channel 0 wins first.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // values from before this edge, independent of statement order.
    if (rst) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_busy      <= 1'b0;
      r_grant_idx <= '0;
      r_ptr       <= IDX_W'(NUMBER_CHANNELS - 1);
    end else begin
      r_state     <= w_next_state;
      r_gnt       <= w_next_gnt;
      r_busy      <= w_next_busy;
      r_grant_idx <= w_next_idx;
      r_ptr       <= w_next_ptr;
    end
  end

  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign grant_idx = r_grant_idx;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter. Expected grants are queued
// when requests are driven and popped when the DUT raises a grant.
// Define ARB_TIMEOUT_EN to exercise the stall watchdog.
module tb_output_port_arbiter;

  localparam int NC = 5;
  localparam int IW = 3;
  localparam int TC = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] req;
  logic [NC-1:0] last;
  logic          ready;
  logic [NC-1:0] gnt;
  logic [NC-1:0] ack;
  logic          busy;
  logic [IW-1:0] grant_idx;
  logic          timeout;

  int            total = 0;
  int            bad   = 0;
  logic [NC-1:0] exp_q[$];
  logic [NC-1:0] exp_g;

  output_port_arbiter #(
    .NUMBER_CHANNELS (NC),
    .IDX_W           (IW),
    .TIMEOUT_CYCLES  (TC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .ready     (ready),
    .gnt       (gnt),
    .ack       (ack),
    .busy      (busy),
    .grant_idx (grant_idx),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=still_running want=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input int max_cycles, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < max_cycles) begin
      step();
      cycles++;
      if (busy === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = '0;
    last  = '0;
    ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int c;
    bit s;
    rst   = 1'b1;
    req   = 5'b11111;
    last  = '0;
    ready = 1'b0;
    step();
    step();
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL rst_gnt: got=%b want=%b", gnt, 5'b00000); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got=%b want=0", busy); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got=%b want=0", timeout); end
    total++; if (grant_idx !== 3'd0) begin bad++; $display("FAIL rst_idx: got=%0d want=0", grant_idx); end
    exp_q.push_back(5'b00001);
    rst = 1'b0;
    wait_busy(3, c, s);
    total++;
    if (!s) begin
      bad++; $display("FAIL rst_first_grant: got=no_grant want=grant");
    end else begin
      exp_g = exp_q.pop_front();
      if (gnt !== exp_g) begin bad++; $display("FAIL rst_first_grant: got=%b want=%b", gnt, exp_g); end
      total++; if (c !== 1) begin bad++; $display("FAIL rst_latency: got=%0d want=1", c); end
    end
  endtask

  task automatic test_single_burst();
    do_reset();
    exp_q.push_back(5'b00100);
    req   = 5'b00100;
    ready = 1'b1;
    last  = '0;
    step();
    exp_g = exp_q.pop_front();
    total++; if (gnt !== exp_g) begin bad++; $display("FAIL sb_gnt: got=%b want=%b", gnt, exp_g); end
    total++; if (grant_idx !== 3'd2) begin bad++; $display("FAIL sb_idx: got=%0d want=2", grant_idx); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL sb_busy: got=%b want=1", busy); end
    total++; if (ack !== 5'b00100) begin bad++; $display("FAIL sb_ack1: got=%b want=%b", ack, 5'b00100); end
    step();
    total++; if (ack !== 5'b00100) begin bad++; $display("FAIL sb_ack2: got=%b want=%b", ack, 5'b00100); end
    step();
    last = 5'b00100;
    #1;
    total++; if (ack !== 5'b00100) begin bad++; $display("FAIL sb_ack3: got=%b want=%b", ack, 5'b00100); end
    step();
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL sb_release: got=%b want=%b", gnt, 5'b00000); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sb_idle_busy: got=%b want=0", busy); end
    total++; if (grant_idx !== 3'd2) begin bad++; $display("FAIL sb_idx_hold: got=%0d want=2", grant_idx); end
    req  = '0;
    last = '0;
  endtask

  task automatic test_round_robin();
    int c;
    bit s;
    do_reset();
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b01000);
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b01000);
    req   = 5'b01001;
    ready = 1'b1;
    last  = '0;
    for (int b = 0; b < 4; b++) begin
      wait_busy(4, c, s);
      total++;
      if (!s) begin
        bad++; $display("FAIL rr_wait%0d: got=no_grant want=grant", b);
      end else begin
        exp_g = exp_q.pop_front();
        if (gnt !== exp_g) begin bad++; $display("FAIL rr_gnt%0d: got=%b want=%b", b, gnt, exp_g); end
        total++; if (ack !== exp_g) begin bad++; $display("FAIL rr_ack%0d: got=%b want=%b", b, ack, exp_g); end
        total++; if (c !== 1) begin bad++; $display("FAIL rr_latency%0d: got=%0d want=1", b, c); end
        step();
        last = 5'b11111;
        step();
        last = '0;
        total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL rr_idle%0d: got=%b want=%b", b, gnt, 5'b00000); end
      end
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    int c;
    bit s;
    do_reset();
    exp_q.push_back(5'b00010);
    req   = 5'b00010;
    ready = 1'b0;
    last  = '0;
    wait_busy(4, c, s);
    total++;
    if (!s) begin
      bad++; $display("FAIL bp_wait: got=no_grant want=grant");
    end else begin
      exp_g = exp_q.pop_front();
      if (gnt !== exp_g) begin bad++; $display("FAIL bp_gnt: got=%b want=%b", gnt, exp_g); end
    end
    req  = 5'b10010;
    last = 5'b00010;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (gnt !== 5'b00010) begin bad++; $display("FAIL bp_hold%0d: got=%b want=%b", i, gnt, 5'b00010); end
      total++; if (ack !== 5'b00000) begin bad++; $display("FAIL bp_noack%0d: got=%b want=%b", i, ack, 5'b00000); end
      step();
    end
    exp_q.push_back(5'b10000);
    ready = 1'b1;
    #1;
    total++; if (ack !== 5'b00010) begin bad++; $display("FAIL bp_beat: got=%b want=%b", ack, 5'b00010); end
    step();
    last = '0;
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL bp_release: got=%b want=%b", gnt, 5'b00000); end
    step();
    exp_g = exp_q.pop_front();
    total++; if (gnt !== exp_g) begin bad++; $display("FAIL bp_next: got=%b want=%b", gnt, exp_g); end
    total++; if (grant_idx !== 3'd4) begin bad++; $display("FAIL bp_next_idx: got=%0d want=4", grant_idx); end
    req   = '0;
    ready = 1'b0;
  endtask

  task automatic test_wrap();
    int c;
    bit s;
    do_reset();
    exp_q.push_back(5'b10000);
    req   = 5'b10000;
    ready = 1'b1;
    last  = 5'b11111;
    wait_busy(4, c, s);
    total++;
    if (!s) begin
      bad++; $display("FAIL wrap_first_wait: got=no_grant want=grant");
    end else begin
      exp_g = exp_q.pop_front();
      if (gnt !== exp_g) begin bad++; $display("FAIL wrap_first: got=%b want=%b", gnt, exp_g); end
    end
    exp_q.push_back(5'b00010);
    exp_q.push_back(5'b10000);
    req = 5'b10010;
    for (int b = 0; b < 2; b++) begin
      step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_idle%0d: got=%b want=0", b, busy); end
      wait_busy(3, c, s);
      total++;
      if (!s) begin
        bad++; $display("FAIL wrap_wait%0d: got=no_grant want=grant", b);
      end else begin
        exp_g = exp_q.pop_front();
        if (gnt !== exp_g) begin bad++; $display("FAIL wrap_gnt%0d: got=%b want=%b", b, gnt, exp_g); end
      end
    end
    req   = '0;
    last  = '0;
    ready = 1'b0;
  endtask

  task automatic test_burst_lock();
    int c;
    bit s;
    do_reset();
    exp_q.push_back(5'b01000);
    req   = 5'b01000;
    ready = 1'b1;
    last  = '0;
    wait_busy(4, c, s);
    total++;
    if (!s) begin
      bad++; $display("FAIL lock_wait: got=no_grant want=grant");
    end else begin
      exp_g = exp_q.pop_front();
      if (gnt !== exp_g) begin bad++; $display("FAIL lock_gnt: got=%b want=%b", gnt, exp_g); end
    end
    req  = 5'b00001;
    last = 5'b11111;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (gnt !== 5'b01000) begin bad++; $display("FAIL lock_hold%0d: got=%b want=%b", i, gnt, 5'b01000); end
      total++; if (ack !== 5'b00000) begin bad++; $display("FAIL lock_noack%0d: got=%b want=%b", i, ack, 5'b00000); end
      step();
    end
    req = 5'b01000;
    #1;
    total++; if (ack !== 5'b01000) begin bad++; $display("FAIL lock_beat: got=%b want=%b", ack, 5'b01000); end
    step();
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL lock_release: got=%b want=%b", gnt, 5'b00000); end
    req  = '0;
    last = '0;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int c;
    bit s;
    do_reset();
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00100);
    req   = 5'b00001;
    ready = 1'b1;
    last  = '0;
    wait_busy(4, c, s);
    total++;
    if (!s) begin
      bad++; $display("FAIL tmo_wait: got=no_grant want=grant");
    end else begin
      exp_g = exp_q.pop_front();
      if (gnt !== exp_g) begin bad++; $display("FAIL tmo_gnt: got=%b want=%b", gnt, exp_g); end
    end
    req = 5'b00100;
    for (int i = 0; i < TC; i++) begin
      total++; if (gnt !== 5'b00001) begin bad++; $display("FAIL tmo_hold%0d: got=%b want=%b", i, gnt, 5'b00001); end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_early%0d: got=%b want=0", i, timeout); end
      step();
    end
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL tmo_pulse: got=%b want=1", timeout); end
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL tmo_release: got=%b want=%b", gnt, 5'b00000); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy: got=%b want=0", busy); end
    step();
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_pulse_end: got=%b want=0", timeout); end
    exp_g = exp_q.pop_front();
    total++; if (gnt !== exp_g) begin bad++; $display("FAIL tmo_next: got=%b want=%b", gnt, exp_g); end
    req = '0;
  endtask
`else
  task automatic test_hold_forever();
    int c;
    bit s;
    do_reset();
    exp_q.push_back(5'b00001);
    req   = 5'b00001;
    ready = 1'b1;
    last  = '0;
    wait_busy(4, c, s);
    total++;
    if (!s) begin
      bad++; $display("FAIL hold_wait: got=no_grant want=grant");
    end else begin
      exp_g = exp_q.pop_front();
      if (gnt !== exp_g) begin bad++; $display("FAIL hold_gnt: got=%b want=%b", gnt, exp_g); end
    end
    req = 5'b00100;
    for (int i = 0; i < 20; i++) begin
      step();
      total++; if (gnt !== 5'b00001) begin bad++; $display("FAIL hold_gnt%0d: got=%b want=%b", i, gnt, 5'b00001); end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL hold_timeout%0d: got=%b want=0", i, timeout); end
    end
    req = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_burst_lock();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold_forever();
`endif
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
